// File: rtl/mem_dma_if.sv
// rtl/mem_dma_if.sv - control and memory-bus signal bundle for mem_dma
//
// Purpose: groups the copy-request handshake (start/src/dst/len/busy/done)
// and the single-port word memory bus (address/wf/w/v) driven by mem_dma.
// Modports:
//   master - the copy engine: takes the request and read data, drives
//            status, address, write flag and write data.
//   slave  - the surrounding CPU control logic plus memory: the mirror image.
interface mem_dma_if #(
    parameter int N = 32,
    parameter int M = 16
);
    logic         start;
    logic [M-1:0] src;
    logic [M-1:0] dst;
    logic [M-1:0] len;
    logic         busy;
    logic         done;
    logic [M-1:0] address;
    logic         wf;
    logic [N-1:0] w;
    logic [N-1:0] v;

    modport master (
        input  start, src, dst, len, v,
        output busy, done, address, wf, w
    );

    modport slave (
        output start, src, dst, len, v,
        input  busy, done, address, wf, w
    );
endinterface

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-channel word block-copy engine on a single-port memory
//
// Purpose: on an accepted start, copies len words from src to dst, one word
// per three cycles (read address, capture data, write), ascending order,
// addresses wrapping modulo 2^M.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_dma_if.master: start/src/dst/len in, busy/done out,
//          address/wf/w out to memory, v in from memory (1-cycle read latency)
module mem_dma #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic      clk,
    input  logic      rst,
    mem_dma_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t       state;
    logic [M-1:0] src_r;
    logic [M-1:0] dst_r;
    logic [M-1:0] len_r;
    logic [M-1:0] i;
    logic [N-1:0] d;

    // Registered outputs; each is loaded with the value belonging to the
    // state being entered so it is valid for the whole of that state.
    logic         busy_r;
    logic         done_r;
    logic [M-1:0] address_r;
    logic         wf_r;

    logic [M-1:0] i_next;

    assign i_next = i + M'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            i         <= '0;
            d         <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            address_r <= '0;
            wf_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    busy_r    <= 1'b0;
                    wf_r      <= 1'b0;
                    address_r <= '0;
                    if (bus.start) begin
                        src_r <= bus.src;
                        dst_r <= bus.dst;
                        len_r <= bus.len;
                        i     <= '0;
                        if (bus.len == '0) begin
                            // Empty copy: straight to DONE, no memory access.
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            // i is zero here, so the first read address is src.
                            state     <= RD;
                            busy_r    <= 1'b1;
                            address_r <= bus.src;
                        end
                    end
                end
                RD: begin
                    // Read address is held into CAP so v matches it.
                    state <= CAP;
                end
                CAP: begin
                    d         <= bus.v;
                    state     <= WR;
                    wf_r      <= 1'b1;
                    address_r <= dst_r + i;
                end
                WR: begin
                    wf_r <= 1'b0;
                    i    <= i_next;
                    if (i_next == len_r) begin
                        state     <= DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        address_r <= '0;
                    end else begin
                        state     <= RD;
                        address_r <= src_r + i_next;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy_r    <= 1'b0;
                    wf_r      <= 1'b0;
                    address_r <= '0;
                end
                default: begin
                    state     <= IDLE;
                    busy_r    <= 1'b0;
                    wf_r      <= 1'b0;
                    address_r <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.address = address_r;
    assign bus.wf      = wf_r;
    // Write data is the capture register itself; only meaningful while wf=1.
    assign bus.w       = d;
endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - self-checking bench for mem_dma
module tb_mem_dma;
    localparam int N = 32;
    localparam int M = 16;

    logic clk;
    logic rst;

    mem_dma_if #(.N(N), .M(M)) bus ();

    mem_dma #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] mem     [0:65535];
    logic [N-1:0] ref_mem [0:65535];

    // Memory model: read data appears the cycle after the address.
    always @(posedge clk) begin
        bus.v <= mem[bus.address];
        if (bus.wf) mem[bus.address] = bus.w;
    end

    // Scoreboard of expected writes: {address, data}.
    logic [M+N-1:0] wq[$];

    always @(negedge clk) begin
        if (!rst && bus.wf) begin
            logic [M+N-1:0] e;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", bus.address, bus.w);
            end else begin
                e = wq.pop_front();
                if ({bus.address, bus.w} !== e) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                             bus.address, bus.w, e[M+N-1:N], e[N-1:0]);
                end
            end
            checks++;
            if (!bus.busy) begin
                errors++;
                $display("FAIL wf_without_busy busy=%b expected 1", bus.busy);
            end
        end
    end

    typedef struct {
        logic [M-1:0] src;
        logic [M-1:0] dst;
        logic [M-1:0] len;
        int           exp_done;  // cycle after start edge with done=1, -1 = never
        int           exp_busy;  // cycles with busy=1
        int           poke;      // cycle to re-assert start with another dst, 0 = none
        int           rstc;      // cycle during which rst is high, 0 = none
        int           n_wr;      // words actually written
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        int done_at;
        int done_cnt;
        int busy_cnt;
        int budget;
        logic [M-1:0] a;
        // Reference model: ascending word-by-word copy.
        for (int j = 0; j < t.n_wr; j++) begin
            logic [M-1:0] as;
            logic [M-1:0] ad;
            as = t.src + M'(j);
            ad = t.dst + M'(j);
            ref_mem[ad] = ref_mem[as];
            wq.push_back({ad, ref_mem[ad]});
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.src   = t.src;
        bus.dst   = t.dst;
        bus.len   = t.len;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        budget   = 3 * int'(t.len) + 8;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (bus.busy) busy_cnt++;
            if (t.rstc != 0 && c == t.rstc + 1) begin
                chk("rst_mid_busy", 64'(bus.busy), 64'd0);
                chk("rst_mid_wf", 64'(bus.wf), 64'd0);
                chk("rst_mid_addr", 64'(bus.address), 64'd0);
            end
            if (t.len == '0) begin
                chk("len0_addr", 64'(bus.address), 64'd0);
            end
            if (t.poke != 0 && c == t.poke) begin
                bus.start = 1'b1;
                bus.dst   = 16'h0400;
            end else begin
                bus.start = 1'b0;
            end
            rst = (t.rstc != 0 && c == t.rstc);
        end
        rst = 1'b0;
        chk("done_cycle", 64'(done_at), 64'(t.exp_done));
        chk("done_count", 64'(done_cnt), (t.exp_done < 0) ? 64'd0 : 64'd1);
        chk("busy_cycles", 64'(busy_cnt), 64'(t.exp_busy));
        chk("writes_pending", 64'(wq.size()), 64'd0);
        wq.delete();
        for (int j = 0; j < 3; j++) begin
            a = t.dst + M'(j);
            chk($sformatf("mem_dst_%h", a), 64'(mem[a]), 64'(ref_mem[a]));
            a = 16'h0400 + M'(j);
            chk($sformatf("mem_alt_%h", a), 64'(mem[a]), 64'(ref_mem[a]));
        end
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) begin
            mem[k]     = 32'h5000_0000 | k;
            ref_mem[k] = 32'h5000_0000 | k;
        end
        mem[16'h0001] = 32'hcafebabe; ref_mem[16'h0001] = 32'hcafebabe;
        mem[16'h0010] = 32'h11111111; ref_mem[16'h0010] = 32'h11111111;
        mem[16'h0011] = 32'h22222222; ref_mem[16'h0011] = 32'h22222222;
        mem[16'h0012] = 32'h33333333; ref_mem[16'h0012] = 32'h33333333;
        mem[16'hffff] = 32'hdeadbeef; ref_mem[16'hffff] = 32'hdeadbeef;
        mem[16'h0000] = 32'h12345678; ref_mem[16'h0000] = 32'h12345678;
        mem[16'h0020] = 32'ha5a5a5a5; ref_mem[16'h0020] = 32'ha5a5a5a5;

        //          src       dst       len    done busy poke rstc n_wr
        tbl[0] = '{16'h0001, 16'h0002, 16'd1,  4,   3,   0,   0,   1};
        tbl[1] = '{16'h0010, 16'h0100, 16'd3,  10,  9,   0,   0,   3};
        tbl[2] = '{16'hffff, 16'h0200, 16'd2,  7,   6,   0,   0,   2};
        tbl[3] = '{16'h0030, 16'h0040, 16'd0,  1,   0,   0,   0,   0};
        tbl[4] = '{16'h0010, 16'h0300, 16'd3,  10,  9,   2,   0,   3};
        tbl[5] = '{16'h0020, 16'h0021, 16'd3,  10,  9,   0,   0,   3};

        bus.start = 1'b0;
        bus.src   = '0;
        bus.dst   = '0;
        bus.len   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_wf", 64'(bus.wf), 64'd0);
        chk("reset_addr", 64'(bus.address), 64'd0);
        chk("reset_w", 64'(bus.w), 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 6; n++) begin
            run_vec(tbl[n]);
            repeat (2) @(negedge clk);
        end

        // Replicated first word on dst = src + 1.
        chk("overlap_w2", 64'(mem[16'h0023]), 64'h00000000a5a5a5a5);

        // Reset during CAP of word 1: only word 0 lands at the destination.
        begin
            vec_t r;
            r = '{16'h0010, 16'h0500, 16'd3, -1, 5, 0, 5, 1};
            run_vec(r);
        end
        chk("rst_word0", 64'(mem[16'h0500]), 64'h0000000011111111);

        // Engine is usable again after the abandoned copy.
        run_vec('{16'h0011, 16'h0600, 16'd1, 4, 3, 0, 0, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
